// File: rtl/mov_ext_if.sv
// rtl/mov_ext_if.sv - Immediate move/extend request and result signal bundle
interface mov_ext_if #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16
);
    logic             MovEn;
    logic             MovOp;
    logic [IN_W-1:0]  MovIn;
    logic [OUT_W-1:0] MovOut;
    logic             MovOutValid;

    modport master (
        output MovEn,
        output MovOp,
        output MovIn,
        input  MovOut,
        input  MovOutValid
    );

    modport slave (
        input  MovEn,
        input  MovOp,
        input  MovIn,
        output MovOut,
        output MovOutValid
    );
endinterface

// File: rtl/mov_ext.sv
// rtl/mov_ext.sv - Registered zero/sign extension of an immediate to a register word
module mov_ext #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16
) (
    input  logic     clk,
    input  logic     rst,
    mov_ext_if.slave bus
);
    localparam int EXT_W = OUT_W - IN_W;

    logic [OUT_W-1:0] mov_out_d,       mov_out_q;
    logic             mov_out_valid_d, mov_out_valid_q;
    logic             ext_bit;

    // Fill bit for the upper word: zero for MovOp=0, immediate MSB for MovOp=1.
    assign ext_bit = bus.MovOp & bus.MovIn[IN_W-1];

    always_comb begin
        mov_out_d       = mov_out_q;
        mov_out_valid_d = 1'b0;
        if (bus.MovEn) begin
            mov_out_d       = {{EXT_W{ext_bit}}, bus.MovIn};
            mov_out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mov_out_q       <= '0;
            mov_out_valid_q <= 1'b0;
        end else begin
            mov_out_q       <= mov_out_d;
            mov_out_valid_q <= mov_out_valid_d;
        end
    end

    assign bus.MovOut      = mov_out_q;
    assign bus.MovOutValid = mov_out_valid_q;
endmodule

// File: tb/tb_mov_ext.sv
// tb/tb_mov_ext.sv - Directed-vector self-checking bench for mov_ext
module tb_mov_ext;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    mov_ext_if #(.IN_W(8), .OUT_W(16)) bus ();

    mov_ext #(.IN_W(8), .OUT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic op, input logic [7:0] imm);
        bus.MovEn = en;
        bus.MovOp = op;
        bus.MovIn = imm;
    endtask

    task automatic expect_out(input string tag, input logic [15:0] exp_out, input logic exp_vld);
        check({tag, "_out"}, {16'h0, bus.MovOut}, {16'h0, exp_out});
        check({tag, "_vld"}, {31'h0, bus.MovOutValid}, {31'h0, exp_vld});
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        drive(1'b1, 1'b1, 8'hFF);
        cyc();
        cyc();
        expect_out("reset", 16'h0000, 1'b0);

        rst = 1'b0;
        drive(1'b0, 1'b0, 8'h00);
        cyc();
        expect_out("idle", 16'h0000, 1'b0);

        drive(1'b1, 1'b0, 8'hFF); cyc(); expect_out("ff_zext", 16'h00FF, 1'b1);
        drive(1'b1, 1'b1, 8'hFF); cyc(); expect_out("ff_sext", 16'hFFFF, 1'b1);
        drive(1'b1, 1'b0, 8'h01); cyc(); expect_out("01_zext", 16'h0001, 1'b1);
        drive(1'b1, 1'b1, 8'h01); cyc(); expect_out("01_sext", 16'h0001, 1'b1);
        drive(1'b1, 1'b1, 8'h80); cyc(); expect_out("80_sext", 16'hFF80, 1'b1);
        drive(1'b1, 1'b0, 8'h80); cyc(); expect_out("80_zext", 16'h0080, 1'b1);
        drive(1'b1, 1'b1, 8'h7F); cyc(); expect_out("7f_sext", 16'h007F, 1'b1);

        drive(1'b0, 1'b1, 8'h55); cyc(); expect_out("hold_a", 16'h007F, 1'b0);
        drive(1'b0, 1'b0, 8'hAA); cyc(); expect_out("hold_b", 16'h007F, 1'b0);

        drive(1'b1, 1'b0, 8'h00); cyc(); expect_out("00_zext", 16'h0000, 1'b1);
        drive(1'b1, 1'b1, 8'h00); cyc(); expect_out("00_sext", 16'h0000, 1'b1);

        // Output must not follow inputs between edges.
        drive(1'b1, 1'b1, 8'hC3); cyc(); expect_out("c3_sext", 16'hFFC3, 1'b1);
        drive(1'b1, 1'b0, 8'h12); #2;
        expect_out("no_comb", 16'hFFC3, 1'b1);
        cyc(); expect_out("12_zext", 16'h0012, 1'b1);

        drive(1'b1, 1'b1, 8'hAA); cyc(); expect_out("aa_sext", 16'hFFAA, 1'b1);
        rst = 1'b1;
        drive(1'b1, 1'b1, 8'hFF); cyc(); expect_out("mid_rst", 16'h0000, 1'b0);
        rst = 1'b0;
        drive(1'b1, 1'b1, 8'h81); cyc(); expect_out("post_rst", 16'hFF81, 1'b1);
        drive(1'b0, 1'b0, 8'h00); cyc(); expect_out("final", 16'hFF81, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
